mio_mem_responder: RTL and testbench

// Memory-side responder for the CPU memory-I/O handshake: accepts the CPU's load/store requests
// (request strobe, read/write select, address, Fun3 access size).

---
 rtl/mio_mem_responder.sv | 160 ++++++++++++++++
 tb/tb_mio_mem_responder.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/mio_mem_responder.sv
// Wait-stated memory responder for the CPU memory-I/O handshake.
// Performs byte/half/word loads and stores on a word-organised RAM and returns a one-cycle MIO_ready pulse.
module mio_mem_responder #(
  parameter int ADDR_BITS   = 10,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        CPU_MIO,
  input  logic        MemRW,
  input  logic [2:0]  Fun3,
  input  logic [31:0] Addr_in,
  input  logic [31:0] Data_out,
  output logic        MIO_ready,
  output logic [31:0] Data_in,
  output logic        mio_err,
  output logic        busy
);

  // state | meaning
  // IDLE  | waiting for CPU_MIO; request fields taken from the live inputs
  // WAIT  | wait states counting down on the latched request
  // RESP  | MIO_ready pulse; access already committed on the entry edge
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        accept, commit;
  logic        rw_q;
  logic [2:0]  fun3_q;
  logic [31:0] addr_q, wdata_q;

  logic [31:0] mem [2**ADDR_BITS];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    commit  = 1'b0;
    case (state_q)
      IDLE: begin
        if (CPU_MIO) begin
          accept = 1'b1;
          cnt_d  = 4'(WAIT_CYCLES);
          if (WAIT_CYCLES == 0) begin
            state_d = RESP;
            commit  = 1'b1;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) begin
          state_d = RESP;
          commit  = 1'b1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // With zero wait states the access commits on the accept edge, so use the live request.
  logic        cur_rw;
  logic [2:0]  cur_fun3;
  logic [31:0] cur_addr, cur_wdata;
  assign cur_rw    = (state_q == IDLE) ? MemRW    : rw_q;
  assign cur_fun3  = (state_q == IDLE) ? Fun3     : fun3_q;
  assign cur_addr  = (state_q == IDLE) ? Addr_in  : addr_q;
  assign cur_wdata = (state_q == IDLE) ? Data_out : wdata_q;

  logic [ADDR_BITS-1:0] idx;
  assign idx = cur_addr[ADDR_BITS+1:2];

  logic acc_err;
  always_comb begin
    acc_err = 1'b0;
    if (cur_addr[31:ADDR_BITS+2] != '0) acc_err = 1'b1;
    if (cur_fun3[1:0] == 2'b01 && cur_addr[0]) acc_err = 1'b1;
    if (cur_fun3 == 3'b010 && cur_addr[1:0] != 2'b00) acc_err = 1'b1;
    if (cur_rw && cur_fun3 != 3'b000 && cur_fun3 != 3'b001 && cur_fun3 != 3'b010) acc_err = 1'b1;
    if (!cur_rw && (cur_fun3 == 3'b011 || cur_fun3 == 3'b110 || cur_fun3 == 3'b111)) acc_err = 1'b1;
  end

  logic [3:0]  wr_be;
  logic [31:0] wr_data;
  always_comb begin
    wr_be   = 4'b0000;
    wr_data = cur_wdata;
    case (cur_fun3[1:0])
      2'b00: begin
        wr_be   = 4'b0001 << cur_addr[1:0];
        wr_data = {4{cur_wdata[7:0]}};
      end
      2'b01: begin
        wr_be   = cur_addr[1] ? 4'b1100 : 4'b0011;
        wr_data = {2{cur_wdata[15:0]}};
      end
      2'b10:   wr_be = 4'b1111;
      default: wr_be = 4'b0000;
    endcase
  end

  logic [31:0] rd_word, rd_bsh, rd_hsh, ld_val;
  assign rd_word = mem[idx];
  assign rd_bsh  = rd_word >> {cur_addr[1:0], 3'b000};
  assign rd_hsh  = rd_word >> {cur_addr[1], 4'b0000};
  always_comb begin
    case (cur_fun3)
      3'b000:  ld_val = {{24{rd_bsh[7]}}, rd_bsh[7:0]};
      3'b100:  ld_val = {24'd0, rd_bsh[7:0]};
      3'b001:  ld_val = {{16{rd_hsh[15]}}, rd_hsh[15:0]};
      3'b101:  ld_val = {16'd0, rd_hsh[15:0]};
      3'b010:  ld_val = rd_word;
      default: ld_val = 32'd0;
    endcase
  end

  // RAM has no reset; contents survive rst.
  always_ff @(posedge clk) begin
    if (commit && !rst && cur_rw && !acc_err) begin
      for (int i = 0; i < 4; i++) begin
        if (wr_be[i]) mem[idx][i*8 +: 8] <= wr_data[i*8 +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      rw_q    <= 1'b0;
      fun3_q  <= 3'd0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      Data_in <= 32'd0;
      mio_err <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        rw_q    <= MemRW;
        fun3_q  <= Fun3;
        addr_q  <= Addr_in;
        wdata_q <= Data_out;
      end
      if (commit) begin
        mio_err <= acc_err;
        if (acc_err)     Data_in <= 32'd0;
        else if (!cur_rw) Data_in <= ld_val;
      end
    end
  end

  assign MIO_ready = (state_q == RESP);
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_mio_mem_responder.sv
// Directed bench for mio_mem_responder: one instance with two wait states, one with none.
// Expected values are hand-computed from the access rules.
module tb_mio_mem_responder;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        cpu_mio, cpu_mio0, mem_rw;
  logic [2:0]  fun3;
  logic [31:0] addr, wdata;
  logic        ready, err, busy, ready0, err0, busy0;
  logic [31:0] rdata, rdata0;

  int n_cmp = 0;
  int n_bad = 0;

  mio_mem_responder #(.ADDR_BITS(10), .WAIT_CYCLES(2)) dut (
    .clk(clk), .rst(rst), .CPU_MIO(cpu_mio), .MemRW(mem_rw), .Fun3(fun3),
    .Addr_in(addr), .Data_out(wdata), .MIO_ready(ready), .Data_in(rdata),
    .mio_err(err), .busy(busy)
  );

  mio_mem_responder #(.ADDR_BITS(10), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst), .CPU_MIO(cpu_mio0), .MemRW(mem_rw), .Fun3(fun3),
    .Addr_in(addr), .Data_out(wdata), .MIO_ready(ready0), .Data_in(rdata0),
    .mio_err(err0), .busy(busy0)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Issue one request, then watch five cycles after the accept edge.
  task automatic txn(input bit sel, input logic rw, input logic [2:0] f3,
                     input logic [31:0] a, input logic [31:0] d,
                     output int rdy_at, output int n_rdy, output logic [4:0] bmask,
                     output logic [31:0] rd, output logic e);
    @(negedge clk);
    mem_rw = rw; fun3 = f3; addr = a; wdata = d;
    if (sel) cpu_mio0 = 1'b1; else cpu_mio = 1'b1;
    @(posedge clk);
    #1;
    cpu_mio = 1'b0; cpu_mio0 = 1'b0;
    rdy_at = 0; n_rdy = 0; bmask = '0; rd = 'x; e = 1'bx;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      if (sel ? ready0 : ready) begin
        if (n_rdy == 0) begin
          rdy_at = c;
          rd = sel ? rdata0 : rdata;
          e  = sel ? err0 : err;
        end
        n_rdy++;
      end
      bmask[c-1] = sel ? busy0 : busy;
    end
  endtask

  task automatic access(input string tag, input bit sel, input logic rw, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] d,
                        input logic [31:0] exp_data, input logic exp_err);
    int rdy_at, n_rdy;
    logic [4:0] bm;
    logic [31:0] rd;
    logic e;
    txn(sel, rw, f3, a, d, rdy_at, n_rdy, bm, rd, e);
    chk({tag, "/lat"}, 32'(rdy_at), sel ? 32'd1 : 32'd3);
    chk({tag, "/npulse"}, 32'(n_rdy), 32'd1);
    chk({tag, "/data"}, rd, exp_data);
    chk({tag, "/err"}, {31'd0, e}, {31'd0, exp_err});
  endtask

  initial begin
    int rdy_at, n_rdy;
    logic [4:0] bm;
    logic [31:0] rd;
    logic e;
    logic [11:0] rmask;
    logic [7:0] rmask0;

    rst = 1'b1; cpu_mio = 1'b0; cpu_mio0 = 1'b0;
    mem_rw = 1'b0; fun3 = 3'd0; addr = 32'd0; wdata = 32'd0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst/ready", {31'd0, ready}, 32'd0);
    chk("rst/busy", {31'd0, busy}, 32'd0);
    chk("rst/data", rdata, 32'd0);
    chk("rst/err", {31'd0, err}, 32'd0);
    chk("rst/ready0", {31'd0, ready0}, 32'd0);

    // Store word: pulse timing and busy window
    txn(1'b0, 1'b1, 3'b010, 32'h10, 32'hDEADBEEF, rdy_at, n_rdy, bm, rd, e);
    chk("sw/lat", 32'(rdy_at), 32'd3);
    chk("sw/npulse", 32'(n_rdy), 32'd1);
    chk("sw/busy", {27'd0, bm}, 32'h07);
    chk("sw/err", {31'd0, e}, 32'd0);
    chk("sw/data", rd, 32'd0);

    access("lb13",  1'b0, 1'b0, 3'b000, 32'h13, 32'd0, 32'hFFFFFFDE, 1'b0);
    access("lbu13", 1'b0, 1'b0, 3'b100, 32'h13, 32'd0, 32'h000000DE, 1'b0);
    access("lhu12", 1'b0, 1'b0, 3'b101, 32'h12, 32'd0, 32'h0000DEAD, 1'b0);
    access("lh10",  1'b0, 1'b0, 3'b001, 32'h10, 32'd0, 32'hFFFFBEEF, 1'b0);
    access("lw10",  1'b0, 1'b0, 3'b010, 32'h10, 32'd0, 32'hDEADBEEF, 1'b0);

    // Partial stores; Data_in keeps the previous load result
    access("sb11",   1'b0, 1'b1, 3'b000, 32'h11, 32'h12345655, 32'hDEADBEEF, 1'b0);
    access("lw10b",  1'b0, 1'b0, 3'b010, 32'h10, 32'd0, 32'hDEAD55EF, 1'b0);
    access("sh12",   1'b0, 1'b1, 3'b001, 32'h12, 32'h0000A5A5, 32'hDEAD55EF, 1'b0);
    access("lw10c",  1'b0, 1'b0, 3'b010, 32'h10, 32'd0, 32'hA5A555EF, 1'b0);

    // Error cases
    access("lw12err",  1'b0, 1'b0, 3'b010, 32'h12,   32'd0, 32'd0, 1'b1);
    access("sw1000",   1'b0, 1'b1, 3'b010, 32'h1000, 32'h11111111, 32'd0, 1'b1);
    access("lf3err",   1'b0, 1'b0, 3'b011, 32'h10,   32'd0, 32'd0, 1'b1);
    access("sh11err",  1'b0, 1'b1, 3'b001, 32'h11,   32'h0000FFFF, 32'd0, 1'b1);
    access("sbuerr",   1'b0, 1'b1, 3'b100, 32'h10,   32'h000000FF, 32'd0, 1'b1);
    access("lw10d",    1'b0, 1'b0, 3'b010, 32'h10,   32'd0, 32'hA5A555EF, 1'b0);

    // Reset in cycle 1 aborts the store
    access("sw20", 1'b0, 1'b1, 3'b010, 32'h20, 32'hCAFEF00D, 32'hA5A555EF, 1'b0);
    @(negedge clk);
    mem_rw = 1'b1; fun3 = 3'b010; addr = 32'h20; wdata = 32'h12345678; cpu_mio = 1'b1;
    @(posedge clk);
    #1 cpu_mio = 1'b0; rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    n_rdy = 0; bm = '0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (ready) n_rdy++;
      bm[c] = busy;
    end
    chk("abort/npulse", 32'(n_rdy), 32'd0);
    chk("abort/busy", {27'd0, bm}, 32'd0);
    access("lw20", 1'b0, 1'b0, 3'b010, 32'h20, 32'd0, 32'hCAFEF00D, 1'b0);

    // Back-to-back with CPU_MIO held high, two wait states
    @(negedge clk);
    mem_rw = 1'b0; fun3 = 3'b010; addr = 32'h10; cpu_mio = 1'b1;
    @(posedge clk);
    rmask = '0;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      rmask[c-1] = ready;
    end
    cpu_mio = 1'b0;
    chk("b2b2/ready", {20'd0, rmask}, 32'h444);
    chk("b2b2/data", rdata, 32'hA5A555EF);
    repeat (4) @(posedge clk);

    // Zero wait states
    access("w0sw4", 1'b1, 1'b1, 3'b010, 32'h4, 32'h0BADF00D, 32'd0, 1'b0);
    access("w0lb7", 1'b1, 1'b0, 3'b000, 32'h7, 32'd0, 32'h0000000B, 1'b0);
    @(negedge clk);
    mem_rw = 1'b0; fun3 = 3'b010; addr = 32'h4; cpu_mio0 = 1'b1;
    @(posedge clk);
    rmask0 = '0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      rmask0[c-1] = ready0;
    end
    cpu_mio0 = 1'b0;
    chk("b2b0/ready", {24'd0, rmask0}, 32'h55);
    chk("b2b0/data", rdata0, 32'h0BADF00D);
    repeat (3) @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
